freq_meter_core: RTL
====================

Name: freq_meter_core

Overview:
- Gated frequency counter, directly downstream of the clock divider.
- Consumes the divider's 1 Hz gate square wave and counts rising edges of an external asynchronous signal during each gate-high phase.
- Scales the count to Hz and converts it to 8-digit packed BCD for the display/scan stage.
- Publishes binary and BCD results with a one-cycle valid strobe.

Parameters:
- CNT_W, 27, width of the edge counter (saturates at 2^CNT_W-1).
- GATE_SHIFT, 1, left shift applied to the raw count (gate-high phase = 0.5 s, so x2 gives Hz).
- BCD_MAX, 99999999, largest displayable result; larger results flag overflow.

Ports:
- clk  input  1  system clock, 100 MHz.
- clr_n  input  1  asynchronous active-low reset.
- gate_1hz  input  1  gate from the divider, synchronous to clk; a window is one high phase.
- sig_in  input  1  measured signal, asynchronous to clk; must be below clk/2.
- freq_bin  output  32  last result in Hz (count << GATE_SHIFT, zero-extended).
- freq_bcd  output  32  last result as 8 packed BCD digits, digit 7 in [31:28].
- overflow  output  1  last result exceeded BCD_MAX or the counter saturated.
- valid  output  1  one-cycle pulse when freq_bin/freq_bcd/overflow update.
- busy  output  1  high in COUNT and CONVERT.

Behaviour:
- Reset (clr_n=0, async): freq_bin=0, freq_bcd=0, overflow=0, valid=0, busy=0, counter=0, state=IDLE, sig synchronizer flops=0, gate_d=1.
  - Because gate_d resets to 1, a gate already high at reset release is not treated as a rising edge. The first window starts at the next genuine rise.
- sig_in path:
  - 2-flop synchronizer, then a third flop.
  - sig_rise = s2 & ~s3. A sig_in edge produces sig_rise 2-3 clocks later.
- gate_1hz path:
  - gate_d registers gate_1hz.
  - g_rise = gate_1hz & ~gate_d.
  - g_fall = ~gate_1hz & gate_d.
- State machine: IDLE, COUNT, CONVERT, DONE.
  - IDLE: on g_rise, counter<=0 and go to COUNT. sig_rise in the g_rise cycle is not counted.
  - COUNT: each sig_rise increments the counter.
    - At all-ones the counter holds and sets sat_flag.
    - On g_fall: latch result = counter << GATE_SHIFT into the 32-bit work register, go to CONVERT. sig_rise in the g_fall cycle is not counted.
  - CONVERT: sequential double-dabble, 32 iterations, one per clock.
    - Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd,bin} left by 1.
    - After iteration 32, go to DONE.
    - If result > BCD_MAX or sat_flag: the BCD output is forced to 0x99999999 and overflow is set.
    - g_rise and g_fall are ignored in CONVERT; a window that began during CONVERT is skipped.
  - DONE (one cycle): load freq_bin, freq_bcd and overflow; valid=1; clear sat_flag; go to IDLE.
    - A g_rise in the DONE cycle is ignored.
- Latency: valid is high exactly 34 clocks after the g_fall cycle (1 latch + 32 convert + 1 done). Outputs hold until the next valid.
- busy = (state==COUNT)|(state==CONVERT).
- Outputs change only in DONE or at reset. There is no partial update.
- Reset mid-COUNT or mid-CONVERT: immediate return to reset values. The previous result is lost and no valid is issued.

Test Plan:
- Reset release with gate_1hz held high, sig_in toggling -> no valid until gate goes low then high and completes a window; all outputs 0 meanwhile.
- Bench gate high for 1000 clk, sig_in period 10 clk (100 rising edges), GATE_SHIFT=1 -> valid 34 clk after g_fall cycle; freq_bin=200; freq_bcd=0x00000200; overflow=0.
- Real divider gate (0.5 s high), sig_in 1 kHz -> freq_bin=1000, freq_bcd=0x00001000; sig_in 12.345678 MHz -> freq_bcd=0x12345678 (±2 Hz).
- Counter forced near saturation (CNT_W=4, 20 edges in window) -> overflow=1, freq_bcd=0x99999999, freq_bin=30.
- sig_in edge aligned so sig_rise lands on the g_fall cycle -> edge not counted (count 100 vs 101 when one cycle earlier).
- clr_n pulsed low for 3 clk mid-CONVERT -> all outputs 0, state IDLE, no valid; next full window measures correctly.

Source files
------------

// File: rtl/freq_meter_core_if.sv
// rtl/freq_meter_core_if.sv - result bus of the gated frequency meter
interface freq_meter_core_if;
  logic [31:0] freq_bin;
  logic [31:0] freq_bcd;
  logic        overflow;
  logic        valid;
  logic        busy;

  modport master (output freq_bin, freq_bcd, overflow, valid, busy);
  modport slave  (input  freq_bin, freq_bcd, overflow, valid, busy);
endinterface

// File: rtl/freq_meter_core.sv
// rtl/freq_meter_core.sv - gated edge counter with Hz scaling and double-dabble BCD conversion
module freq_meter_core #(
  parameter int unsigned CNT_W      = 27,
  parameter int unsigned GATE_SHIFT = 1,
  parameter logic [31:0] BCD_MAX    = 32'd99999999
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               gate_1hz,
  input  logic               sig_in,
  freq_meter_core_if.master  res
);

  typedef enum logic [1:0] {IDLE, COUNT, CONVERT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;

  logic             sig_s1;
  logic             sig_s2;
  logic             sig_s3;
  logic             gate_d;
  logic             sig_rise;
  logic             g_rise;
  logic             g_fall;

  logic [CNT_W-1:0] cnt;
  logic             sat_flag;
  logic [31:0]      result;
  logic [31:0]      res_q;
  logic             ovf_q;
  logic [31:0]      bin_w;
  logic [31:0]      bcd_w;
  logic [31:0]      bcd_adj;
  logic [63:0]      dd_shift;
  logic [4:0]       iter;

  logic [31:0]      freq_bin_q;
  logic [31:0]      freq_bcd_q;
  logic             overflow_q;
  logic             valid_q;

  assign sig_rise = sig_s2 & ~sig_s3;
  assign g_rise   = gate_1hz & ~gate_d;
  assign g_fall   = ~gate_1hz & gate_d;

  // Raw count scaled to Hz; the gate-high phase is a fraction of a second
  assign result = 32'(cnt) << GATE_SHIFT;

  // Resynchronise sig_in and keep a delayed gate for edge detection; gate_d
  // resets high so a gate already high at release is not taken as a rise
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sig_s1 <= 1'b0;
      sig_s2 <= 1'b0;
      sig_s3 <= 1'b0;
      gate_d <= 1'b1;
    end else begin
      sig_s1 <= sig_in;
      sig_s2 <= sig_s1;
      sig_s3 <= sig_s2;
      gate_d <= gate_1hz;
    end
  end

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: gate edges only matter in IDLE and COUNT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (g_rise) state_nxt = COUNT;
      COUNT:   if (g_fall) state_nxt = CONVERT;
      CONVERT: if (iter == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift {bcd,bin} left
  always_comb begin
    bcd_adj = bcd_w;
    for (int i = 0; i < 8; i++) begin
      if (bcd_w[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_w[4*i +: 4] + 4'd3;
      end
    end
    dd_shift = {bcd_adj, bin_w} << 1;
  end

  // Counting, result latch and iterative conversion
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt      <= '0;
      sat_flag <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      bin_w    <= '0;
      bcd_w    <= '0;
      iter     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (g_rise) cnt <= '0;
        end
        COUNT: begin
          if (g_fall) begin
            res_q <= result;
            ovf_q <= (result > BCD_MAX) || sat_flag;
            bin_w <= result;
            bcd_w <= '0;
            iter  <= '0;
          end else if (sig_rise) begin
            if (&cnt) sat_flag <= 1'b1;
            else      cnt      <= cnt + 1'b1;
          end
        end
        CONVERT: begin
          bcd_w <= dd_shift[63:32];
          bin_w <= dd_shift[31:0];
          iter  <= iter + 1'b1;
        end
        DONE: begin
          sat_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Publish results as a unit with a one-cycle strobe
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      freq_bin_q <= '0;
      freq_bcd_q <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= (state == DONE);
      if (state == DONE) begin
        freq_bin_q <= res_q;
        freq_bcd_q <= ovf_q ? 32'h9999_9999 : bcd_w;
        overflow_q <= ovf_q;
      end
    end
  end

  assign res.freq_bin = freq_bin_q;
  assign res.freq_bcd = freq_bcd_q;
  assign res.overflow = overflow_q;
  assign res.valid    = valid_q;
  assign res.busy     = (state == COUNT) || (state == CONVERT);

endmodule
